conv_sequencer: RTL and testbench

Multi-cycle controller that owns the shared ALU while a convolution job runs. On `start` it fetches `len` operand pairs over a single-port data-memory read interface and issues each pair to the ALU with the convolution opcode. It accumulates the ALU results into a signed saturating 32-bit sum and stalls the core pipeline until the job completes. When idle it passes the execute stage's ALU operands through unchanged.

---
 rtl/conv_sequencer_pkg.sv | 39 +++
 rtl/sat_acc32.sv | 42 ++++
 rtl/conv_sequencer.sv | 154 +++++++++++++++
 tb/tb_conv_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sequencer_pkg.sv
// Shared constants, state encoding and saturating-add helper for the convolution sequencer.
package conv_sequencer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ST_W   = 3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] ALU_CONV = 3'b111;
    localparam logic [2:0] ALU_ADD  = 3'b000;

    localparam logic [DATA_W-1:0] WORD_STRIDE = 32'd4;
    localparam logic [DATA_W-1:0] ACC_MAX     = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] ACC_MIN     = 32'h8000_0000;

    typedef struct packed {
        logic              sat;
        logic [DATA_W-1:0] sum;
    } acc_res_t;

    // Signed add clamped to the 32-bit range; overflow only when both signs agree and the result's differs.
    function automatic acc_res_t sat_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        acc_res_t          res;
        logic [DATA_W-1:0] raw;
        raw     = a + b;
        res.sat = 1'b0;
        res.sum = raw;
        if ((a[DATA_W-1] == b[DATA_W-1]) && (raw[DATA_W-1] != a[DATA_W-1])) begin
            res.sat = 1'b1;
            res.sum = a[DATA_W-1] ? ACC_MIN : ACC_MAX;
        end
        return res;
    endfunction

endpackage

// File: rtl/sat_acc32.sv
// Signed saturating 32-bit accumulator with clear, enable and sticky saturation flag.
// The _c outputs are look-ahead values that already include this cycle's clear or addend.
module sat_acc32
    import conv_sequencer_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_addend,
    output logic [DATA_W-1:0] o_sum_c,
    output logic              o_sat_c
);

    logic [DATA_W-1:0] r_sum;
    logic              r_sat;
    acc_res_t          w_add;

    always_comb begin
        w_add   = sat_add(r_sum, i_addend);
        o_sum_c = r_sum;
        o_sat_c = r_sat;
        if (i_clr) begin
            o_sum_c = '0;
            o_sat_c = 1'b0;
        end else if (i_en) begin
            o_sum_c = w_add.sum;
            o_sat_c = r_sat | w_add.sat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sum <= '0;
            r_sat <= 1'b0;
        end else begin
            r_sum <= o_sum_c;
            r_sat <= o_sat_c;
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Convolution job controller: fetches operand pairs, borrows the shared ALU and accumulates results
// while stalling the core; passes the execute-stage operands through when idle.
module conv_sequencer
    import conv_sequencer_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_src_a_base,
    input  logic [DATA_W-1:0] i_src_b_base,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [DATA_W-1:0] i_core_alu_a,
    input  logic [DATA_W-1:0] i_core_alu_b,
    input  logic [2:0]        i_core_alu_ctrl,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [2:0]        o_alu_ctrl,
    input  logic [DATA_W-1:0] i_alu_result,
    output logic              o_mem_rd,
    output logic [DATA_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_busy,
    output logic              o_stall,
    output logic              o_done,
    output logic [DATA_W-1:0] o_conv_result,
    output logic              o_sat
);

    logic [ST_W-1:0]   r_state;
    logic [DATA_W-1:0] r_ptr_a;
    logic [DATA_W-1:0] r_ptr_b;
    logic [LEN_W-1:0]  r_remain;
    logic [DATA_W-1:0] r_op_a;
    logic              r_mem_rd;
    logic [DATA_W-1:0] r_mem_addr;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_conv_result;
    logic              r_sat;

    logic [ST_W-1:0]   w_state_nxt;
    logic [DATA_W-1:0] w_ptr_a_nxt;
    logic [DATA_W-1:0] w_ptr_b_nxt;
    logic [LEN_W-1:0]  w_remain_nxt;
    logic              w_acc_clr;
    logic              w_acc_en;
    logic [DATA_W-1:0] w_acc_sum;
    logic              w_acc_sat;

    sat_acc32 u_acc (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (w_acc_clr),
        .i_en     (w_acc_en),
        .i_addend (i_alu_result),
        .o_sum_c  (w_acc_sum),
        .o_sat_c  (w_acc_sat)
    );

    // Next state, pointer updates and ALU operand mux.
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_a_nxt  = r_ptr_a;
        w_ptr_b_nxt  = r_ptr_b;
        w_remain_nxt = r_remain;
        w_acc_clr    = 1'b0;
        w_acc_en     = 1'b0;
        o_alu_a      = i_core_alu_a;
        o_alu_b      = i_core_alu_b;
        o_alu_ctrl   = i_core_alu_ctrl;
        if (r_state != S_IDLE) begin
            o_alu_a    = '0;
            o_alu_b    = '0;
            o_alu_ctrl = ALU_ADD;
        end
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_ptr_a_nxt  = i_src_a_base;
                    w_ptr_b_nxt  = i_src_b_base;
                    w_remain_nxt = i_len;
                    w_acc_clr    = 1'b1;
                    w_state_nxt  = (i_len == '0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: w_state_nxt = S_RD_B;
            S_RD_B: w_state_nxt = S_EXEC;
            S_EXEC: begin
                // B operand comes straight off the read bus to save a capture cycle.
                o_alu_a      = r_op_a;
                o_alu_b      = i_mem_rdata;
                o_alu_ctrl   = ALU_CONV;
                w_acc_en     = 1'b1;
                w_ptr_a_nxt  = r_ptr_a + WORD_STRIDE;
                w_ptr_b_nxt  = r_ptr_b + WORD_STRIDE;
                w_remain_nxt = r_remain - LEN_W'(1);
                w_state_nxt  = (r_remain == LEN_W'(1)) ? S_DONE : S_RD_A;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs, all derived from the upcoming state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ptr_a       <= '0;
            r_ptr_b       <= '0;
            r_remain      <= '0;
            r_op_a        <= '0;
            r_mem_rd      <= 1'b0;
            r_mem_addr    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_conv_result <= '0;
            r_sat         <= 1'b0;
        end else begin
            r_ptr_a    <= w_ptr_a_nxt;
            r_ptr_b    <= w_ptr_b_nxt;
            r_remain   <= w_remain_nxt;
            if (r_state == S_RD_B) begin
                r_op_a <= i_mem_rdata;
            end
            r_mem_rd   <= (w_state_nxt == S_RD_A) || (w_state_nxt == S_RD_B);
            r_mem_addr <= (w_state_nxt == S_RD_A) ? w_ptr_a_nxt :
                          (w_state_nxt == S_RD_B) ? w_ptr_b_nxt : '0;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DONE) begin
                r_conv_result <= w_acc_sum;
                r_sat         <= w_acc_sat;
            end
        end
    end

    assign o_mem_rd      = r_mem_rd;
    assign o_mem_addr    = r_mem_addr;
    assign o_busy        = r_busy;
    assign o_stall       = r_busy;
    assign o_done        = r_done;
    assign o_conv_result = r_conv_result;
    assign o_sat         = r_sat;

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: memory and ALU stubs plus a wide-integer reference model.
module tb_conv_sequencer;

    localparam int unsigned LEN_W  = 8;
    localparam longint      ACC_HI = 64'sd2147483647;
    localparam longint      ACC_LO = -64'sd2147483648;

    logic             clk, rst, start;
    logic [31:0]      src_a_base, src_b_base;
    logic [LEN_W-1:0] len;
    logic [31:0]      core_alu_a, core_alu_b;
    logic [2:0]       core_alu_ctrl;
    logic [31:0]      alu_a, alu_b, alu_result;
    logic [2:0]       alu_ctrl;
    logic             mem_rd;
    logic [31:0]      mem_addr, mem_rdata;
    logic             busy, stall, done, sat;
    logic [31:0]      conv_result;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] rd_q [$];
    logic [31:0] ta [$];
    logic [31:0] tb [$];
    int          rd_base;
    int          n_pass, n_total;

    int          obs_done_cyc, obs_done_cnt, obs_busy_first, obs_busy_last, obs_busy_cnt, obs_stall_neq;
    logic [31:0] obs_result, obs_start_alu_a;
    logic        obs_sat, obs_start_stall;

    conv_sequencer #(.LEN_W(LEN_W)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_src_a_base    (src_a_base),
        .i_src_b_base    (src_b_base),
        .i_len           (len),
        .i_core_alu_a    (core_alu_a),
        .i_core_alu_b    (core_alu_b),
        .i_core_alu_ctrl (core_alu_ctrl),
        .o_alu_a         (alu_a),
        .o_alu_b         (alu_b),
        .o_alu_ctrl      (alu_ctrl),
        .i_alu_result    (alu_result),
        .o_mem_rd        (mem_rd),
        .o_mem_addr      (mem_addr),
        .i_mem_rdata     (mem_rdata),
        .o_busy          (busy),
        .o_stall         (stall),
        .o_done          (done),
        .o_conv_result   (conv_result),
        .o_sat           (sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign alu_result = (alu_ctrl == 3'b111) ? alu_a + alu_b : alu_a ^ alu_b;

    // One-cycle read latency memory; also logs every read address.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            rd_q.push_back(mem_addr);
        end
    end

    // Reference: clamp a wide running sum of (A+B mod 2^32) after every tap.
    function automatic logic [32:0] model_conv();
        longint      acc;
        bit          s;
        logic [31:0] p;
        acc = 0;
        s   = 1'b0;
        foreach (ta[i]) begin
            p   = ta[i] + tb[i];
            acc = acc + longint'($signed(p));
            if (acc > ACC_HI) begin
                acc = ACC_HI;
                s   = 1'b1;
            end else if (acc < ACC_LO) begin
                acc = ACC_LO;
                s   = 1'b1;
            end
        end
        return {s, 32'(acc)};
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] ab, input logic [31:0] bb, input int i);
        return (i % 2 == 0) ? ab + 32'(4 * (i / 2)) : bb + 32'(4 * (i / 2));
    endfunction

    // Drive one job and record what the DUT did; pulse_k>0 re-pulses start in that cycle after T.
    task automatic run_job(input logic [31:0] ab, input logic [31:0] bb, input int n, input int pulse_k);
        mem.delete();
        for (int i = 0; i < n; i++) begin
            mem[ab + 32'(4 * i)] = ta[i];
            mem[bb + 32'(4 * i)] = tb[i];
        end
        obs_done_cyc = -1; obs_done_cnt = 0; obs_busy_first = -1; obs_busy_last = -1;
        obs_busy_cnt = 0;  obs_stall_neq = 0; obs_result = 'x;   obs_sat = 1'bx;
        @(posedge clk); #1;
        rd_base       = rd_q.size();
        start         = 1'b1;
        src_a_base    = ab;
        src_b_base    = bb;
        len           = LEN_W'(n);
        core_alu_a    = $urandom;
        core_alu_b    = $urandom;
        core_alu_ctrl = 3'($urandom);
        #1;
        obs_start_stall = stall;
        obs_start_alu_a = alu_a;
        @(posedge clk); #1;
        for (int k = 1; k <= 3 * n + 4; k++) begin
            start = (k == pulse_k);
            if (busy === 1'b1) begin
                if (obs_busy_first < 0) obs_busy_first = k;
                obs_busy_last = k;
                obs_busy_cnt++;
            end
            if (stall !== busy) obs_stall_neq++;
            if (done === 1'b1) begin
                obs_done_cnt++;
                obs_done_cyc = k;
                obs_result   = conv_result;
                obs_sat      = sat;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; len = '0; src_a_base = '0; src_b_base = '0;
        core_alu_a = 32'h1234_5678; core_alu_b = 32'h9ABC_DEF0; core_alu_ctrl = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd: got %b want 0", mem_rd); else n_pass++;
        n_total++; if (sat !== 1'b0) $display("FAIL reset_sat: got %b want 0", sat); else n_pass++;
        n_total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
        n_total++; if (conv_result !== 32'h0) $display("FAIL reset_conv_result: got %h want 0", conv_result); else n_pass++;
        n_total++; if (alu_a !== 32'h1234_5678) $display("FAIL reset_alu_a: got %h want 12345678", alu_a); else n_pass++;
        n_total++; if (alu_ctrl !== 3'b010) $display("FAIL reset_alu_ctrl: got %b want 010", alu_ctrl); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_passthrough();
        logic [31:0] a, b;
        logic [2:0]  c;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 32'd5 : $urandom;
            b = (i == 0) ? 32'd7 : $urandom;
            c = (i == 0) ? 3'b000 : 3'($urandom);
            core_alu_a = a; core_alu_b = b; core_alu_ctrl = c;
            @(posedge clk); #1;
            n_total++; if (alu_a !== a) $display("FAIL pass_alu_a[%0d]: got %h want %h", i, alu_a, a); else n_pass++;
            n_total++; if (alu_b !== b) $display("FAIL pass_alu_b[%0d]: got %h want %h", i, alu_b, b); else n_pass++;
            n_total++; if (alu_ctrl !== c) $display("FAIL pass_alu_ctrl[%0d]: got %b want %b", i, alu_ctrl, c); else n_pass++;
            n_total++; if (stall !== 1'b0) $display("FAIL pass_stall[%0d]: got %b want 0", i, stall); else n_pass++;
        end
    endtask

    task automatic test_three_tap();
        logic [31:0] exp_rd [6];
        exp_rd = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};
        ta = {32'd1, 32'd2, 32'd3};
        tb = {32'd10, 32'd20, 32'd30};
        run_job(32'h100, 32'h200, 3, 0);
        n_total++; if (obs_done_cyc !== 10) $display("FAIL tap3_done_cycle: got %0d want 10", obs_done_cyc); else n_pass++;
        n_total++; if (obs_done_cnt !== 1) $display("FAIL tap3_done_count: got %0d want 1", obs_done_cnt); else n_pass++;
        n_total++; if (obs_result !== 32'd66) $display("FAIL tap3_result: got %0d want 66", obs_result); else n_pass++;
        n_total++; if (obs_sat !== 1'b0) $display("FAIL tap3_sat: got %b want 0", obs_sat); else n_pass++;
        n_total++; if (obs_busy_first !== 1 || obs_busy_last !== 10 || obs_busy_cnt !== 10)
            $display("FAIL tap3_busy_window: got %0d..%0d (%0d cycles) want 1..10 (10 cycles)", obs_busy_first, obs_busy_last, obs_busy_cnt);
        else n_pass++;
        n_total++; if (obs_stall_neq !== 0) $display("FAIL tap3_stall_eq_busy: got %0d differing cycles want 0", obs_stall_neq); else n_pass++;
        n_total++; if (obs_start_stall !== 1'b0) $display("FAIL tap3_start_cycle_stall: got %b want 0", obs_start_stall); else n_pass++;
        n_total++; if (obs_start_alu_a !== core_alu_a) $display("FAIL tap3_start_cycle_pass: got %h want %h", obs_start_alu_a, core_alu_a); else n_pass++;
        n_total++; if (rd_q.size() - rd_base !== 6) $display("FAIL tap3_read_count: got %0d want 6", rd_q.size() - rd_base); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (rd_base + i >= rd_q.size()) $display("FAIL tap3_read_addr[%0d]: got none want %h", i, exp_rd[i]);
            else if (rd_q[rd_base + i] !== exp_rd[i]) $display("FAIL tap3_read_addr[%0d]: got %h want %h", i, rd_q[rd_base + i], exp_rd[i]);
            else n_pass++;
        end
    endtask

    task automatic test_zero_len();
        ta.delete(); tb.delete();
        run_job(32'h400, 32'h500, 0, 0);
        n_total++; if (obs_done_cyc !== 1) $display("FAIL zero_done_cycle: got %0d want 1", obs_done_cyc); else n_pass++;
        n_total++; if (obs_done_cnt !== 1) $display("FAIL zero_done_count: got %0d want 1", obs_done_cnt); else n_pass++;
        n_total++; if (obs_result !== 32'd0) $display("FAIL zero_result: got %h want 0", obs_result); else n_pass++;
        n_total++; if (rd_q.size() !== rd_base) $display("FAIL zero_no_reads: got %0d reads want 0", rd_q.size() - rd_base); else n_pass++;
        n_total++; if (obs_busy_cnt !== 1) $display("FAIL zero_busy_cycles: got %0d want 1", obs_busy_cnt); else n_pass++;
    endtask

    task automatic test_saturation();
        ta = {32'h7FFF_FFF0, 32'h7FFF_FFF0};
        tb = {32'h0, 32'h0};
        run_job(32'h800, 32'h900, 2, 0);
        n_total++; if (obs_result !== 32'h7FFF_FFFF) $display("FAIL sat_result: got %h want 7fffffff", obs_result); else n_pass++;
        n_total++; if (obs_sat !== 1'b1) $display("FAIL sat_flag: got %b want 1", obs_sat); else n_pass++;
        n_total++; if (sat !== 1'b1) $display("FAIL sat_flag_held: got %b want 1", sat); else n_pass++;
        ta = {32'd1};
        tb = {32'd1};
        run_job(32'hA00, 32'hB00, 1, 0);
        n_total++; if (obs_result !== 32'd2) $display("FAIL sat_next_result: got %h want 2", obs_result); else n_pass++;
        n_total++; if (obs_sat !== 1'b0) $display("FAIL sat_next_flag: got %b want 0", obs_sat); else n_pass++;
    endtask

    task automatic test_busy_start();
        logic [32:0] m;
        ta = {32'd3, 32'd9, 32'd27};
        tb = {32'd100, 32'd200, 32'd300};
        m  = model_conv();
        run_job(32'hC00, 32'hD00, 3, 4);
        n_total++; if (obs_done_cnt !== 1) $display("FAIL busy_start_done_count: got %0d want 1", obs_done_cnt); else n_pass++;
        n_total++; if (obs_done_cyc !== 10) $display("FAIL busy_start_done_cycle: got %0d want 10", obs_done_cyc); else n_pass++;
        n_total++; if (obs_result !== m[31:0]) $display("FAIL busy_start_result: got %h want %h", obs_result, m[31:0]); else n_pass++;
        n_total++; if (obs_busy_cnt !== 10) $display("FAIL busy_start_busy_cycles: got %0d want 10", obs_busy_cnt); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_rd [4];
        exp_rd = '{32'hFFFF_FFFC, 32'h300, 32'h0, 32'h304};
        ta = {32'd5, 32'd6};
        tb = {32'd7, 32'd8};
        run_job(32'hFFFF_FFFC, 32'h300, 2, 0);
        n_total++; if (obs_result !== 32'd26) $display("FAIL wrap_result: got %0d want 26", obs_result); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (rd_base + i >= rd_q.size()) $display("FAIL wrap_read_addr[%0d]: got none want %h", i, exp_rd[i]);
            else if (rd_q[rd_base + i] !== exp_rd[i]) $display("FAIL wrap_read_addr[%0d]: got %h want %h", i, rd_q[rd_base + i], exp_rd[i]);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        int dn;
        ta = {32'd1, 32'd2, 32'd3};
        tb = {32'd10, 32'd20, 32'd30};
        mem.delete();
        for (int i = 0; i < 3; i++) begin
            mem[32'h100 + 32'(4 * i)] = ta[i];
            mem[32'h200 + 32'(4 * i)] = tb[i];
        end
        @(posedge clk); #1;
        start = 1'b1; src_a_base = 32'h100; src_b_base = 32'h200; len = LEN_W'(3);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_total++; if (alu_ctrl !== 3'b111) $display("FAIL midrst_in_exec: got ctrl %b want 111", alu_ctrl); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL midrst_stall: got %b want 0", stall); else n_pass++;
        n_total++; if (mem_rd !== 1'b0) $display("FAIL midrst_mem_rd: got %b want 0", mem_rd); else n_pass++;
        n_total++; if (conv_result !== 32'h0) $display("FAIL midrst_conv_result: got %h want 0", conv_result); else n_pass++;
        n_total++; if (alu_ctrl !== core_alu_ctrl) $display("FAIL midrst_passthrough: got %b want %b", alu_ctrl, core_alu_ctrl); else n_pass++;
        dn = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done === 1'b1) dn++;
        end
        n_total++; if (dn !== 0) $display("FAIL midrst_no_done: got %0d pulses want 0", dn); else n_pass++;
        rst = 1'b1;
        ta = {32'd4};
        tb = {32'd5};
        run_job(32'h600, 32'h700, 1, 0);
        n_total++; if (obs_done_cyc !== 4) $display("FAIL midrst_after_done_cycle: got %0d want 4", obs_done_cyc); else n_pass++;
        n_total++; if (obs_result !== 32'd9) $display("FAIL midrst_after_result: got %0d want 9", obs_result); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            int          n, pk, mode;
            logic [31:0] ab, bb;
            logic [32:0] m;
            n  = $urandom_range(1, 6);
            ab = $urandom & 32'hFFFF_FFFC;
            bb = ab ^ 32'h8000_0000;
            ta.delete(); tb.delete();
            for (int i = 0; i < n; i++) begin
                mode = $urandom_range(0, 2);
                if (mode == 0) begin
                    ta.push_back(32'($urandom_range(0, 1000)));
                    tb.push_back(32'($urandom_range(0, 1000)));
                end else if (mode == 1) begin
                    ta.push_back($urandom);
                    tb.push_back($urandom);
                end else begin
                    ta.push_back(32'h6000_0000 | ($urandom & 32'h0FFF_FFFF));
                    tb.push_back(32'h1000_0000);
                end
            end
            pk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3 * n + 1) : 0;
            m  = model_conv();
            run_job(ab, bb, n, pk);
            n_total++; if (obs_done_cyc !== 3 * n + 1) $display("FAIL rnd%0d_done_cycle: got %0d want %0d", it, obs_done_cyc, 3 * n + 1); else n_pass++;
            n_total++; if (obs_done_cnt !== 1) $display("FAIL rnd%0d_done_count: got %0d want 1", it, obs_done_cnt); else n_pass++;
            n_total++; if (obs_result !== m[31:0]) $display("FAIL rnd%0d_result: got %h want %h", it, obs_result, m[31:0]); else n_pass++;
            n_total++; if (obs_sat !== m[32]) $display("FAIL rnd%0d_sat: got %b want %b", it, obs_sat, m[32]); else n_pass++;
            n_total++; if (obs_busy_cnt !== 3 * n + 1 || obs_busy_first !== 1)
                $display("FAIL rnd%0d_busy: got first %0d count %0d want first 1 count %0d", it, obs_busy_first, obs_busy_cnt, 3 * n + 1);
            else n_pass++;
            n_total++; if (rd_q.size() - rd_base !== 2 * n) $display("FAIL rnd%0d_read_count: got %0d want %0d", it, rd_q.size() - rd_base, 2 * n); else n_pass++;
            for (int i = 0; i < 2 * n; i++) begin
                n_total++;
                if (rd_base + i >= rd_q.size()) $display("FAIL rnd%0d_read_addr[%0d]: got none want %h", it, i, exp_addr(ab, bb, i));
                else if (rd_q[rd_base + i] !== exp_addr(ab, bb, i))
                    $display("FAIL rnd%0d_read_addr[%0d]: got %h want %h", it, i, rd_q[rd_base + i], exp_addr(ab, bb, i));
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rd_base = 0;
        test_reset();
        test_passthrough();
        test_three_tap();
        test_zero_len();
        test_saturation();
        test_busy_start();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not complete");
    end

endmodule
